dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width driven to the data RAM.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- cpu_unsigned  in  1  zero-extends loads when 1, sign-extends when 0.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load result, valid while cpu_ack is high.
- cpu_err  out  1  misalignment flag, valid while cpu_ack is high.
- dbg_req  in  1  debug/loader request; held until dbg_ack.
- dbg_we  in  1  debug store when 1.
- dbg_addr  in  32  debug byte address; word only, bits [1:0] ignored.
- dbg_wdata  in  32  debug store word.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  32  debug load word, valid while dbg_ack is high.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address; equals latched addr[ADDR_W+1:2].
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data; registered, valid one cycle after mem_addr is presented.

Function
REQ-003 SHALL implement an FSM with states IDLE, RD, DATA, WR, ACK.
REQ-004 In IDLE, with any request pending, SHALL grant one port, latch its we/addr/wdata/size/unsigned, and move to:
- WR for a word store.
- RD for a load or a sub-word store.
REQ-005 SHALL arbitrate round-robin using a 1-bit last-grant pointer:
- A lone requester always wins.
- When both request, the port not granted last wins.
REQ-006 In RD, SHALL drive mem_addr with mem_we=0, then go to DATA.
REQ-007 In DATA, mem_dout is valid; the block SHALL then do one of:
- Load: register the formatted result, then go to ACK.
- Sub-word store: drive the merged word on mem_din with mem_we=1, then go to ACK.
REQ-008 In WR, SHALL drive mem_we=1 with mem_din equal to the latched wdata, then go to ACK.
REQ-009 In ACK, SHALL pulse exactly one of cpu_ack/dbg_ack for the granted port, then return to IDLE.
REQ-010 A request still high in IDLE after its ACK SHALL be treated as a new request.
REQ-011 Latency from request sampled in IDLE to ack:
- Word store: ack 2 cycles after the sampling edge.
- Load or sub-word store: ack 3 cycles after the sampling edge.
REQ-012 Load formatting:
- Byte: select lane addr[1:0].
- Half: select lane addr[1].
- Shift the selected lane to bits [7:0]/[15:0], then zero- or sign-extend per cpu_unsigned.
- Word: pass through.
REQ-013 Sub-word store merge: replace only the addressed byte/half lane of the read word with wdata[7:0]/[15:0]; all other lanes are unchanged.
REQ-014 mem_we SHALL be high only in WR, or in DATA for a store; it SHALL be decoded from state, never registered separately.
REQ-015 cpu_rdata/dbg_rdata SHALL hold their last value between acks; cpu_err SHALL be 0 except as defined in REQ-020.

Reset
REQ-016 On rst_n low, asynchronously:
- FSM to IDLE; last-grant pointer to DBG, so the CPU wins the first tie.
- cpu_ack, dbg_ack, cpu_err to 0; cpu_rdata, dbg_rdata to 0.
- mem_we to 0 immediately.
REQ-017 A reset asserted mid-transaction SHALL abort it with no ack and no further RAM write; the requester re-issues.

Configuration
REQ-018 The macro DMEM_CTRL_MISALIGN_TRAP_EN SHALL enable misalignment trapping.
REQ-019 Without the macro:
- cpu_err is constant 0.
- Misaligned halves use addr[1] (addr[0] ignored).
- Misaligned words use the word address (addr[1:0] ignored).
REQ-020 With the macro, a CPU half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL:
- Go IDLE->ACK with no RAM access.
- Return cpu_rdata=0 and cpu_err=1 in the ack cycle.
- Take 1-cycle latency.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Word store, then load: CPU stores 0xDEADBEEF at 0x40; ack after 2 cycles; mem_addr=0x10; lw 0x40 returns 0xDEADBEEF after 3 cycles.
- Sub-word store and signed load: RAM 0x11223344 at 0x40; sb 0xAA to 0x41; RAM becomes 0x1122AA44; lb 0x41 returns 0xFFFFFFAA; lbu 0x41 returns 0x000000AA; lhu 0x42 returns 0x00001122.
- Arbitration: cpu_req and dbg_req rise together after reset; CPU acked first, DBG next; with both held continuously, grants alternate CPU/DBG.
- Reset mid-operation: rst_n pulsed low during DATA of an sb; mem_we is 0 throughout; RAM word unchanged; no ack.
- Misalignment trap (macro defined): lw 0x42 gives cpu_ack 1 cycle later, cpu_err=1, cpu_rdata=0, mem_we never high; without the macro, the same access reads the word at 0x40 with cpu_err=0.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// CPU, debug and data-RAM signal bundle for dmem_ctrl.
// slave is the controller's view; master is the requesters plus the RAM.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;
  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_ack;
  logic [31:0]       dbg_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned,
    output cpu_ack, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned,
    input  cpu_ack, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin CPU/debug arbitration, sub-word loads and
// read-modify-write stores. Define DMEM_CTRL_MISALIGN_TRAP_EN to trap misaligned CPU accesses.
module dmem_ctrl #(
  parameter int ADDR_W = 14
) (
  input logic         clk,
  input logic         rst_n,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, ACK} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg;      // 1 = debug port owns the transaction
  logic              last_reg;       // 1 = debug was granted last
  logic              we_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [31:0]       cpu_rdata_reg;
  logic [31:0]       dbg_rdata_reg;

  logic              req_any;
  logic              pick_dbg;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_mis;
  logic [31:0]       load_word;
  logic [31:0]       merge_word;
  logic              unused_addr;

  assign unused_addr = ^{bus.cpu_addr[31:ADDR_W+2], bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};

  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   fmt_load = {{24{~uns & b[7]}}, b};
      2'b01:   fmt_load = {{16{~uns & h[15]}}, h};
      default: fmt_load = word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] wdata);
    merge_store = word;
    case (size)
      2'b00: merge_store[8*off +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) merge_store[31:16] = wdata[15:0];
        else        merge_store[15:0]  = wdata[15:0];
      end
      default: merge_store = wdata;
    endcase
  endfunction

  // Tie goes to the port that was not served last.
  assign req_any  = bus.cpu_req | bus.dbg_req;
  assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_reg);
  assign sel_we   = pick_dbg ? bus.dbg_we : bus.cpu_we;
  assign sel_size = pick_dbg ? 2'b10 : bus.cpu_size;

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  logic err_reg;
  assign sel_mis = ~pick_dbg & (((bus.cpu_size == 2'b01) & bus.cpu_addr[0]) |
                                (bus.cpu_size[1] & (bus.cpu_addr[1:0] != 2'b00)));
  assign bus.cpu_err = (state_reg == ACK) & ~grant_reg & err_reg;
`else
  assign sel_mis     = 1'b0;
  assign bus.cpu_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          if (sel_mis)                     state_next = ACK;
          else if (sel_we && sel_size[1])  state_next = WR;
          else                             state_next = RD;
        end
      end
      RD:      state_next = DATA;
      DATA:    state_next = ACK;
      WR:      state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= 1'b0;
      last_reg      <= 1'b1;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      cpu_rdata_reg <= '0;
      dbg_rdata_reg <= '0;
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_any) begin
        grant_reg    <= pick_dbg;
        last_reg     <= pick_dbg;
        we_reg       <= sel_we;
        size_reg     <= sel_size;
        addr_reg     <= pick_dbg ? {bus.dbg_addr[ADDR_W+1:2], 2'b00} : bus.cpu_addr[ADDR_W+1:0];
        wdata_reg    <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        unsigned_reg <= pick_dbg ? 1'b0 : bus.cpu_unsigned;
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
        err_reg      <= sel_mis;
        if (sel_mis) cpu_rdata_reg <= '0;
`endif
      end
      if (state_reg == DATA && !we_reg) begin
        if (grant_reg) dbg_rdata_reg <= bus.mem_dout;
        else           cpu_rdata_reg <= load_word;
      end
    end
  end

  assign load_word  = fmt_load(bus.mem_dout, addr_reg[1:0], size_reg, unsigned_reg);
  assign merge_word = merge_store(bus.mem_dout, addr_reg[1:0], size_reg, wdata_reg);

  // Write strobe is a pure state decode so reset kills it without waiting for a clock.
  assign bus.mem_we    = (state_reg == WR) | ((state_reg == DATA) & we_reg);
  assign bus.mem_addr  = addr_reg[ADDR_W+1:2];
  assign bus.mem_din   = (state_reg == DATA) ? merge_word : wdata_reg;
  assign bus.cpu_ack   = (state_reg == ACK) & ~grant_reg;
  assign bus.dbg_ack   = (state_reg == ACK) & grant_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.dbg_rdata = dbg_rdata_reg;

endmodule
